// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide
// on operand magnitudes, with sign correction and divide-by-zero/overflow bypass.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  reqValid,
    input  logic [2:0]            reqCode,
    input  logic [DATA_WIDTH-1:0] reqOp1,
    input  logic [DATA_WIDTH-1:0] reqOp2,
    input  logic [4:0]            reqRd,
    input  logic                  flush,
    output logic                  busy,
    output logic                  respValid,
    output logic [DATA_WIDTH-1:0] respData,
    output logic [4:0]            respRd,
    output logic [1:0]            dbgState
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0] C_MUL    = 3'd0;
    localparam logic [2:0] C_MULH   = 3'd1;
    localparam logic [2:0] C_MULHSU = 3'd2;
    localparam logic [2:0] C_MULHU  = 3'd3;
    localparam logic [2:0] C_DIV    = 3'd4;
    localparam logic [2:0] C_DIVU   = 3'd5;
    localparam logic [2:0] C_REM    = 3'd6;
    localparam logic [2:0] C_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      code_q;
    logic [4:0]      rd_q;
    logic            neg_q;
    logic [W-1:0]    oper_q;
    logic [2*W-1:0]  acc_q;

    logic            accept, finish;
    logic            op1_signed, op2_signed, s1, s2, neg_req;
    logic [W-1:0]    mag1, mag2;
    logic            div_zero, div_ovf, special;
    logic [W-1:0]    special_result;
    logic [W:0]      mul_sum, rem_shift, div_diff;
    logic [2*W-1:0]  mul_next, div_next, acc_step, prod_fix;
    logic [W-1:0]    quo, rem, calc_result;

    assign dbgState = state_q;

    // Request decode: magnitudes, result sign and the bypass cases.
    always_comb begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        case (reqCode)
            C_MUL, C_MULH, C_DIV, C_REM: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            C_MULHSU: op1_signed = 1'b1;
            default: ;
        endcase
        s1       = op1_signed & reqOp1[W-1];
        s2       = op2_signed & reqOp2[W-1];
        mag1     = s1 ? -reqOp1 : reqOp1;
        mag2     = s2 ? -reqOp2 : reqOp2;
        neg_req  = (reqCode == C_REM) ? s1 : (s1 ^ s2);
        div_zero = reqCode[2] && (reqOp2 == '0);
        div_ovf  = ((reqCode == C_DIV) || (reqCode == C_REM)) &&
                   (reqOp1 == {1'b1, {(W-1){1'b0}}}) && (reqOp2 == {W{1'b1}});
        special  = div_zero | div_ovf;
        // REM codes have bit 1 set; DIV codes do not.
        if (div_zero)
            special_result = reqCode[1] ? reqOp1 : {W{1'b1}};
        else
            special_result = reqCode[1] ? '0 : reqOp1;
    end

    // One iteration step; acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, oper_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};
        rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = rem_shift - {1'b0, oper_q};
        div_next  = div_diff[W] ? {rem_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        acc_step  = code_q[2] ? div_next : mul_next;
        prod_fix  = neg_q ? -acc_step : acc_step;
        quo       = acc_step[W-1:0];
        rem       = acc_step[2*W-1:W];
        case (code_q)
            C_MUL:                    calc_result = prod_fix[W-1:0];
            C_MULH, C_MULHSU, C_MULHU: calc_result = prod_fix[2*W-1:W];
            C_DIV, C_DIVU:            calc_result = neg_q ? -quo : quo;
            default:                  calc_result = neg_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        respValid = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqValid && !flush) begin
                    accept  = 1'b1;
                    busy    = 1'b1;
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(W - 1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                respValid = !flush;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy = busy & rstN;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q    <= '0;
            code_q   <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            oper_q   <= '0;
            acc_q    <= '0;
            respData <= '0;
            respRd   <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            code_q <= reqCode;
            rd_q   <= reqRd;
            neg_q  <= neg_req;
            oper_q <= reqCode[2] ? mag2 : mag1;
            acc_q  <= {{W{1'b0}}, (reqCode[2] ? mag1 : mag2)};
            if (special) begin
                respData <= special_result;
                respRd   <= reqRd;
            end
        end else if (state_q == CALC && !flush) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CW'(1);
            if (finish) begin
                respData <= calc_result;
                respRd   <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed RV32M cases plus random ops, checked every cycle
// against an arithmetic reference model and an expected-response queue.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstN;
    logic         reqValid;
    logic [2:0]   reqCode;
    logic [W-1:0] reqOp1, reqOp2;
    logic [4:0]   reqRd;
    logic         flush;
    logic         busy, respValid;
    logic [W-1:0] respData;
    logic [4:0]   respRd;
    logic [1:0]   dbgState;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int          acc;
        int          busy_end;
        int          resp;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        cmp_e;
    logic        cmp_busy, cmp_valid;
    logic [31:0] last_data = '0;
    logic [4:0]  last_rd = '0;

    muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqCode(reqCode),
        .reqOp1(reqOp1), .reqOp2(reqOp2), .reqRd(reqRd), .flush(flush),
        .busy(busy), .respValid(respValid), .respData(respData),
        .respRd(respRd), .dbgState(dbgState)
    );

    // Clock and cycle index.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference results straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (code)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] code, input logic [31:0] a,
                                      input logic [31:0] b);
        return code[2] && ((b == 0) ||
               ((code == 3'd4 || code == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Scoreboard: compares busy, respValid, respData and respRd every cycle.
    always @(negedge clk) begin
        if (!rstN) begin
            check("busy_in_reset", {31'b0, busy}, 32'd0);
            check("valid_in_reset", {31'b0, respValid}, 32'd0);
            check("data_in_reset", respData, 32'd0);
            check("rd_in_reset", {27'b0, respRd}, 32'd0);
        end else begin
            cmp_busy  = 1'b0;
            cmp_valid = 1'b0;
            if (exp_q.size() > 0) begin
                cmp_e     = exp_q[0];
                cmp_busy  = (cyc >= cmp_e.acc) && (cyc <= cmp_e.busy_end);
                cmp_valid = (cyc == cmp_e.resp);
            end
            check("busy", {31'b0, busy}, {31'b0, cmp_busy});
            check("resp_valid", {31'b0, respValid}, {31'b0, cmp_valid});
            if (cmp_valid) begin
                check("resp_data", respData, cmp_e.data);
                check("resp_rd", {27'b0, respRd}, {27'b0, cmp_e.rd});
                last_data = cmp_e.data;
                last_rd   = cmp_e.rd;
                void'(exp_q.pop_front());
            end else begin
                check("resp_data_hold", respData, last_data);
                check("resp_rd_hold", {27'b0, respRd}, {27'b0, last_rd});
                if (exp_q.size() > 0 && cmp_e.resp < 0 && cyc >= cmp_e.busy_end)
                    void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        reqValid = 1'b0;
        repeat (n) step();
    endtask

    // Presents an op and holds it through the DONE cycle, as the stalled pipeline would.
    task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit pin, input logic [31:0] lit);
        exp_t e;
        int   t = cyc;
        bit   sp = is_special(code, a, b);
        if (pin) check("model_pin", model(code, a, b), lit);
        e.acc      = t;
        e.busy_end = sp ? t : t + W;
        e.resp     = sp ? t + 1 : t + W + 1;
        e.data     = model(code, a, b);
        e.rd       = rd;
        exp_q.push_back(e);
        reqValid = 1'b1;
        reqCode  = code;
        reqOp1   = a;
        reqOp2   = b;
        reqRd    = rd;
        while (cyc < e.resp) step();
        step();
        reqValid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t e;
        int   t;
        rstN     = 1'b0;
        reqValid = 1'b1;
        reqCode  = 3'd0;
        reqOp1   = 32'd3;
        reqOp2   = 32'd4;
        reqRd    = 5'd1;
        flush    = 1'b0;
        repeat (3) step();
        reqValid = 1'b0;
        rstN     = 1'b1;
        idle(2);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b1, 32'h4000_0000);
        idle(1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, 32'hFFFF_FFFE);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1, 32'hFFFF_FFFD);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1, 32'hFFFF_FFFF);
        issue(3'd5, 32'd100, 32'd7, 5'd11, 1'b1, 32'd14);
        issue(3'd7, 32'd100, 32'd7, 5'd12, 1'b1, 32'd2);
        issue(3'd4, 32'd5, 32'd0, 5'd13, 1'b1, 32'hFFFF_FFFF);
        issue(3'd7, 32'd5, 32'd0, 5'd14, 1'b1, 32'd5);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h8000_0000);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h0);
        idle(2);

        // Flush at CALC iteration 10, then a new op in the very next cycle.
        t          = cyc;
        e.acc      = t;
        e.busy_end = t + 11;
        e.resp     = -1;
        e.data     = '0;
        e.rd       = '0;
        exp_q.push_back(e);
        reqValid = 1'b1;
        reqCode  = 3'd0;
        reqOp1   = 32'd1234;
        reqOp2   = 32'd5678;
        reqRd    = 5'd20;
        step();
        reqValid = 1'b0;
        while (cyc < t + 11) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        issue(3'd5, 32'd9, 32'd3, 5'd21, 1'b1, 32'd3);

        // Asynchronous reset in the middle of CALC with reqValid still asserted.
        t          = cyc;
        e.acc      = t;
        e.busy_end = t + W;
        e.resp     = t + W + 1;
        e.data     = model(3'd5, 32'd1000, 32'd7);
        e.rd       = 5'd22;
        exp_q.push_back(e);
        reqValid = 1'b1;
        reqCode  = 3'd5;
        reqOp1   = 32'd1000;
        reqOp2   = 32'd7;
        reqRd    = 5'd22;
        while (cyc < t + 15) step();
        #1;
        rstN = 1'b0;
        exp_q.delete();
        last_data = '0;
        last_rd   = '0;
        #1;
        check("rst_busy_now", {31'b0, busy}, 32'd0);
        check("rst_valid_now", {31'b0, respValid}, 32'd0);
        check("rst_data_now", respData, 32'd0);
        check("rst_rd_now", {27'b0, respRd}, 32'd0);
        step();
        step();
        reqValid = 1'b0;
        rstN     = 1'b1;
        idle(40);

        // Back-to-back REMU: second accepted in the IDLE cycle right after the first DONE.
        issue(3'd7, 32'd100, 32'd7, 5'd23, 1'b1, 32'd2);
        issue(3'd7, 32'hFFFF_FFFF, 32'd10, 5'd24, 1'b1, 32'd5);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
                  5'($urandom_range(0, 31)), 1'b0, 32'h0);
            idle($urandom_range(0, 2));
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
